inst_queue: RTL and testbench

- Circular instruction FIFO between the fetcher (InstCache/IF) and the Decoder, directly upstream of issue into the RsvStation.
- Buffers fetched {inst, pc, predicted-jump} triples and releases one per cycle to the Decoder.
- Stalls release while any issue target (RS, ROB, LSB) reports full; flushes on ROB clear (mispredict).
- Provides back-pressure to the fetcher with one slot of slack.

---
 rtl/inst_queue_pkg.sv | 16 +
 rtl/inst_queue.sv | 95 +++++++++
 tb/tb_inst_queue.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_queue_pkg.sv
// Shared sizing constants for the instruction queue and its neighbours.
// The queue top takes its parameter defaults from here.
package inst_queue_pkg;

    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;

    localparam int DataWidth = 32;
    localparam int RSSize    = 16;
    localparam int IQSize    = 16;
    localparam int IQAddrW   = 4;

    typedef logic [IQAddrW-1:0] iq_index_t;
    typedef logic [IQAddrW:0]   iq_count_t;

endpackage

// File: rtl/inst_queue.sv
// Circular instruction FIFO between fetch and decode.
// Registered release, flushed by the ROB on mispredict.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int IQ_DEPTH  = IQSize,
    parameter int IQ_ADDR_W = IQAddrW,
    parameter int DATA_W    = DataWidth
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              IF_input_valid,
    input  logic [DATA_W-1:0] IF_inst,
    input  logic [DATA_W-1:0] IF_inst_pc,
    input  logic              IF_pred_jump,
    output logic              IQ_is_full,
    input  logic              RS_is_full,
    input  logic              ROB_is_full,
    input  logic              LSB_is_full,
    input  logic              ROB_clear,
    output logic              ID_output_valid,
    output logic [DATA_W-1:0] ID_inst,
    output logic [DATA_W-1:0] ID_inst_pc,
    output logic              ID_pred_jump
);

    localparam logic [IQ_ADDR_W:0] CNT_MAX =
        (IQ_ADDR_W+1)'(IQ_DEPTH);
    localparam logic [IQ_ADDR_W:0] FULL_MARK =
        (IQ_ADDR_W+1)'(IQ_DEPTH - 1);

    logic [IQ_ADDR_W-1:0] head;
    logic [IQ_ADDR_W-1:0] tail;
    logic [IQ_ADDR_W:0]   count;

    logic [DATA_W-1:0] inst_mem [IQ_DEPTH];
    logic [DATA_W-1:0] pc_mem   [IQ_DEPTH];
    logic              pj_mem   [IQ_DEPTH];

    logic stall;
    logic pop;
    logic push;

    assign stall = RS_is_full | ROB_is_full | LSB_is_full;
    assign pop   = (count != '0) & ~stall;
    assign push  = IF_input_valid & ((count < CNT_MAX) | pop);

    // One slot of slack covers the fetcher's in-flight request.
    assign IQ_is_full = (count >= FULL_MARK);

    always_ff @(posedge clk) begin
        if (rdy && !ROB_clear && push) begin
            inst_mem[tail] <= IF_inst;
            pc_mem[tail]   <= IF_inst_pc;
            pj_mem[tail]   <= IF_pred_jump;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            ID_output_valid <= 1'b0;
            ID_inst         <= '0;
            ID_inst_pc      <= '0;
            ID_pred_jump    <= 1'b0;
        end else if (rdy) begin
            if (ROB_clear) begin
                head            <= '0;
                tail            <= '0;
                count           <= '0;
                ID_output_valid <= 1'b0;
            end else begin
                ID_output_valid <= pop;
                if (pop) begin
                    ID_inst      <= inst_mem[head];
                    ID_inst_pc   <= pc_mem[head];
                    ID_pred_jump <= pj_mem[head];
                    head         <= head + 1'b1;
                end
                if (push) begin
                    tail <= tail + 1'b1;
                end
                unique case (1'b1)
                    (push & ~pop): count <= count + 1'b1;
                    (pop & ~push): count <= count - 1'b1;
                    default:       count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Randomised scoreboard bench for inst_queue against a queue-based model.
// Monitor pops expected words whenever a live release pulse appears.
module tb_inst_queue;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pj;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        IF_input_valid;
    logic [31:0] IF_inst;
    logic [31:0] IF_inst_pc;
    logic        IF_pred_jump;
    logic        IQ_is_full;
    logic        RS_is_full;
    logic        ROB_is_full;
    logic        LSB_is_full;
    logic        ROB_clear;
    logic        ID_output_valid;
    logic [31:0] ID_inst;
    logic [31:0] ID_inst_pc;
    logic        ID_pred_jump;

    inst_queue dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .IF_input_valid  (IF_input_valid),
        .IF_inst         (IF_inst),
        .IF_inst_pc      (IF_inst_pc),
        .IF_pred_jump    (IF_pred_jump),
        .IQ_is_full      (IQ_is_full),
        .RS_is_full      (RS_is_full),
        .ROB_is_full     (ROB_is_full),
        .LSB_is_full     (LSB_is_full),
        .ROB_clear       (ROB_clear),
        .ID_output_valid (ID_output_valid),
        .ID_inst         (ID_inst),
        .ID_inst_pc      (ID_inst_pc),
        .ID_pred_jump    (ID_pred_jump)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    ent_t m_q[$];
    ent_t exp_q[$];
    bit   m_valid = 1'b0;
    bit   edge_live = 1'b0;
    ent_t snap;
    bit   snap_v;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    always @(posedge clk) edge_live = rdy && rst;

    always @(negedge clk) begin
        if (rst) begin
            if (edge_live) begin
                if (ID_output_valid) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL sb_unexpected: got pc %h want none",
                                 ID_inst_pc);
                    end else begin
                        ent_t e;
                        e = exp_q.pop_front();
                        chk("sb_inst", ID_inst, e.inst);
                        chk("sb_pc", ID_inst_pc, e.pc);
                        chk("sb_pj", 32'(ID_pred_jump), 32'(e.pj));
                    end
                end
            end else begin
                chk("hold_valid", 32'(ID_output_valid), 32'(snap_v));
                chk("hold_inst", ID_inst, snap.inst);
                chk("hold_pc", ID_inst_pc, snap.pc);
                chk("hold_pj", 32'(ID_pred_jump), 32'(snap.pj));
            end
            snap_v    = ID_output_valid;
            snap.inst = ID_inst;
            snap.pc   = ID_inst_pc;
            snap.pj   = ID_pred_jump;
        end
    end

    task automatic step(input bit iv, input logic [31:0] inst,
                        input logic [31:0] pc, input bit rs,
                        input bit rob, input bit lsb,
                        input bit clr, input bit rd);
        bit   stl;
        bit   pop;
        bit   push;
        ent_t e;
        @(negedge clk);
        #1;
        IF_input_valid = iv;
        IF_inst        = inst;
        IF_inst_pc     = pc;
        IF_pred_jump   = 1'($urandom);
        RS_is_full     = rs;
        ROB_is_full    = rob;
        LSB_is_full    = lsb;
        ROB_clear      = clr;
        rdy            = rd;
        chk("iq_full", 32'(IQ_is_full), 32'(m_q.size() >= 15));
        chk("count", 32'(dut.count), m_q.size());
        if (rd) begin
            if (clr) begin
                m_q.delete();
                m_valid = 1'b0;
            end else begin
                stl  = rs | rob | lsb;
                pop  = (m_q.size() != 0) && !stl;
                push = iv && ((m_q.size() < 16) || pop);
                m_valid = pop;
                if (pop) begin
                    e = m_q.pop_front();
                    exp_q.push_back(e);
                end
                if (push) begin
                    e.inst = inst;
                    e.pc   = pc;
                    e.pj   = IF_pred_jump;
                    m_q.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
        chk("valid", 32'(ID_output_valid), 32'(m_valid));
    endtask

    task automatic idle(input int n, input bit rs);
        for (int i = 0; i < n; i++)
            step(0, $urandom, $urandom, rs, 0, 0, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b0;
        rdy            = 1'b1;
        IF_input_valid = 1'b1;
        IF_inst        = 32'h13;
        IF_inst_pc     = '0;
        IF_pred_jump   = 1'b0;
        RS_is_full     = 1'b0;
        ROB_is_full    = 1'b0;
        LSB_is_full    = 1'b0;
        ROB_clear      = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("rst_valid", 32'(ID_output_valid), 0);
            chk("rst_inst", ID_inst, 0);
            chk("rst_pc", ID_inst_pc, 0);
            chk("rst_count", 32'(dut.count), 0);
        end
        IF_input_valid = 1'b0;
        rst = 1'b1;

        // single pass: pulse two edges after the push
        step(1, 32'h13, 32'h0, 0, 0, 0, 0, 1);
        idle(3, 0);

        // fill under stall, 17th push dropped
        for (int i = 0; i < 16; i++)
            step(1, $urandom, 32'(i * 4), 1, 0, 0, 0, 1);
        step(1, $urandom, 32'h40, 1, 0, 0, 0, 1);
        idle(3, 1);
        idle(18, 0);

        // continuous stream
        for (int i = 0; i < 40; i++)
            step(1, $urandom, 32'h1000 + 32'(i * 4), 0, 0, 0, 0, 1);
        idle(3, 0);

        // flush with a push and a stall in the same cycle
        for (int i = 0; i < 8; i++)
            step(1, $urandom, 32'h2000 + 32'(i * 4), 0, 1, 0, 0, 1);
        step(1, $urandom, 32'h100, 0, 0, 1, 1, 1);
        idle(2, 0);
        step(1, $urandom, 32'h200, 0, 0, 0, 0, 1);
        idle(3, 0);

        // rdy freeze with a pulse registered and three queued
        for (int i = 0; i < 4; i++)
            step(1, $urandom, 32'h3000 + 32'(i * 4), 1, 0, 0, 0, 1);
        idle(1, 0);
        for (int i = 0; i < 5; i++)
            step(1'($urandom), $urandom, $urandom,
                 1'($urandom), 0, 1'($urandom), 1'($urandom), 0);
        idle(6, 0);

        // random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom, $urandom,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) != 0);
        idle(20, 0);

        // asynchronous reset between edges with five queued
        for (int i = 0; i < 6; i++)
            step(1, $urandom, 32'h4000 + 32'(i * 4), 1, 0, 0, 0, 1);
        idle(1, 0);
        chk("pre_rst_valid", 32'(ID_output_valid), 32'(m_valid));
        chk("pre_rst_count", 32'(dut.count), m_q.size());
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(ID_output_valid), 0);
        chk("arst_pc", ID_inst_pc, 0);
        m_q.delete();
        m_valid = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        chk("arst_count", 32'(dut.count), 0);
        idle(2, 0);
        step(1, $urandom, 32'h5000, 0, 0, 0, 0, 1);
        step(1, $urandom, 32'h5004, 0, 0, 0, 0, 1);
        idle(4, 0);

        chk("sb_left", exp_q.size(), 0);
        chk("model_left", m_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
